// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one WIDTH-bit operation processed LSB first, one bit per clock,
// with a start/done handshake. A final FIX cycle folds the SLT sign/overflow into bit 0.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       ctrl_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             set_q;

  logic             a_bit, b_bit, sum_bit, carry_nx, ovf_bit, r_bit;
  logic [WIDTH-1:0] res_nx;

  // One bit slice of the ALU, applied to the bit selected by the counter.
  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    a_bit    = a_q[cnt] ^ ctrl_q[3];
    b_bit    = b_q[cnt] ^ ctrl_q[2];
    sum_bit  = a_bit ^ b_bit ^ carry;
    carry_nx = (a_bit & b_bit) | (carry & (a_bit ^ b_bit));
    ovf_bit  = carry ^ carry_nx;
    r_bit    = 1'b0;
    unique case (ctrl_q[1:0])
      2'b00:   r_bit = a_bit & b_bit;
      2'b01:   r_bit = a_bit | b_bit;
      2'b10:   r_bit = sum_bit;
      default: r_bit = 1'b0;  // SLT: less input is 0 while bits stream through
    endcase
    res_nx      = result_o;
    res_nx[cnt] = r_bit;
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      set_q      <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            a_q    <= src1_i;
            b_q    <= src2_i;
            ctrl_q <= ctrl_i;
            cnt    <= '0;
            carry  <= ctrl_i[1] & ctrl_i[2];  // subtract = add ~b + 1
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result_o <= res_nx;
          carry    <= ctrl_q[1] & carry_nx;
          if (cnt == LAST) begin
            cout_o     <= ctrl_q[1] & carry_nx;
            overflow_o <= ctrl_q[1] & ovf_bit;
            set_q      <= sum_bit ^ ovf_bit;
            if (ctrl_q[1:0] == 2'b11) begin
              state <= FIX;
            end else begin
              zero_o <= (res_nx == '0);
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= DONE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          result_o <= {{(WIDTH-1){1'b0}}, set_q};
          zero_o   <= ~set_q;
          busy_o   <= 1'b0;
          done_o   <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;  // DONE
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed corner cases plus random operations,
// compared against a word-level arithmetic model of the ALU.
module tb_alu_serial_seq;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i, src2_i;
  logic             busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [WIDTH-1:0] result_o;

  int total = 0;
  int bad   = 0;

  alu_serial_seq #(.WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ctrl_i(ctrl_i),
    .src1_i(src1_i), .src2_i(src2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: plain two's-complement arithmetic on the (optionally inverted) operands.
  function automatic void model(input logic [3:0] ctrl, input logic [WIDTH-1:0] x, y,
                                output logic [WIDTH-1:0] res, output logic c, output logic v);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   usum, ssum;
    logic             cin;
    a    = ctrl[3] ? ~x : x;
    b    = ctrl[2] ? ~y : y;
    cin  = ctrl[1] & ctrl[2];
    usum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    ssum = {a[WIDTH-1], a} + {b[WIDTH-1], b} + (WIDTH+1)'(cin);
    c = 1'b0;
    v = 1'b0;
    case (ctrl[1:0])
      2'b00: res = a & b;
      2'b01: res = a | b;
      default: begin
        c = usum[WIDTH];
        v = ssum[WIDTH] != ssum[WIDTH-1];
        if (ctrl[1:0] == 2'b10) res = usum[WIDTH-1:0];
        else res = {{(WIDTH-1){1'b0}}, ssum[WIDTH]};  // true sign of the exact difference
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] ctrl,
                        input logic [WIDTH-1:0] x, y, input bit hold);
    logic [WIDTH-1:0] er;
    logic ec, ev;
    int n, lat, pulses;
    model(ctrl, x, y, er, ec, ev);
    lat = (ctrl[1:0] == 2'b11) ? WIDTH + 1 : WIDTH;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = ctrl; src1_i = x; src2_i = y;
    @(posedge clk_i); #1;  // E0
    check({tag, ".busy"}, 64'(busy_o), 64'd1);
    if (!hold) start_i = 1'b0;
    src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'($urandom);
    n = 0;
    while (!done_o && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check({tag, ".latency"}, 64'(n), 64'(lat));
    check({tag, ".result"}, 64'(result_o), 64'(er));
    check({tag, ".zero"}, 64'(zero_o), 64'(er == '0));
    check({tag, ".cout"}, 64'(cout_o), 64'(ec));
    check({tag, ".ovf"}, 64'(overflow_o), 64'(ev));
    start_i = 1'b0;
    pulses = 0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (done_o) pulses++;
    end
    check({tag, ".one_pulse"}, 64'(pulses), 64'd0);
    check({tag, ".idle"}, 64'(busy_o), 64'd0);
    check({tag, ".held"}, 64'(result_o), 64'(er));
  endtask

  initial begin
    logic [3:0] codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    rst_i = 1'b1; start_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0;
    #12;
    check("rst.busy", 64'(busy_o), 64'd0);
    check("rst.done", 64'(done_o), 64'd0);
    check("rst.result", 64'(result_o), 64'd0);
    check("rst.zero", 64'(zero_o), 64'd1);
    check("rst.cout", 64'(cout_o), 64'd0);
    check("rst.ovf", 64'(overflow_o), 64'd0);
    @(negedge clk_i); rst_i = 1'b0;

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 1'b0);
    run_op("and", 4'b0000, 32'hFFFF_0000, 32'h0FF0_0FF0, 1'b0);
    run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("slt_pos", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("nor", 4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 1'b0);
    run_op("or_zero", 4'b0001, 32'h0, 32'h0, 1'b0);
    run_op("hold_start", 4'b0010, 32'h1234_5678, 32'h1111_1111, 1'b1);

    for (int i = 0; i < 30; i++) begin
      logic [3:0] c;
      c = (i % 3 == 2) ? 4'($urandom) : codes[$urandom_range(0, 5)];
      run_op($sformatf("rnd%0d", i), c, $urandom, $urandom, 1'(i % 5 == 0));
    end

    // Asynchronous reset in the middle of an operation.
    run_op("pre_rst", 4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'hFFFF_FFFF; src2_i = 32'hFFFF_FFFF;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("midrst.busy", 64'(busy_o), 64'd0);
    check("midrst.result", 64'(result_o), 64'd0);
    check("midrst.zero", 64'(zero_o), 64'd1);
    check("midrst.done", 64'(done_o), 64'd0);
    @(negedge clk_i); rst_i = 1'b0;
    run_op("add_after_rst", 4'b0010, 32'd3, 32'd4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
